// File: rtl/ram_rf_pkg.sv
// Shared constants, FSM state encoding and address decode for the ram_rf register file.
package ram_rf_pkg;

  localparam int unsigned RAM_DEPTH = 32;
  localparam int unsigned RAM_WIDTH = 16;
  localparam int unsigned RAM_BASE  = 32;
  localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned ADDR_MSB  = 8;
  localparam int unsigned ADDR_LSB  = 3;

  typedef logic [ADDR_MSB:ADDR_LSB] sw_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_INV_RD,
    ST_INV_WR
  } state_t;

  function automatic logic addr_valid(input sw_addr_t a);
    return (32'(a) >= RAM_BASE) && (32'(a) < RAM_BASE + RAM_DEPTH);
  endfunction

  function automatic logic [RAM_AW-1:0] ram_index(input sw_addr_t a);
    return RAM_AW'(32'(a) - RAM_BASE);
  endfunction

endpackage

// File: rtl/ram_rf_dpram.sv
// True dual-port synchronous RAM: read-first on both ports, port A wins a same-index write.
module ram_rf_dpram #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    a_addr,
  input  logic             a_ren,
  input  logic             a_wen,
  input  logic [WIDTH-1:0] a_wdata,
  output logic [WIDTH-1:0] a_rdata,
  input  logic [AW-1:0]    b_addr,
  input  logic             b_ren,
  input  logic             b_wen,
  input  logic [WIDTH-1:0] b_wdata,
  output logic [WIDTH-1:0] b_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Port A is written last so it overrides port B on a collision.
  always_ff @(posedge clk) begin
    if (b_wen) mem[b_addr] <= b_wdata;
    if (a_wen) mem[a_addr] <= a_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_ren) a_rdata <= mem[a_addr];
      if (b_ren) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/ram_rf.sv
// Register-file wrapper exposing TestRAM to the software register bus and a hardware port.
module ram_rf
  import ram_rf_pkg::*;
(
  input  logic                 clk,
  input  logic                 res_n,
  input  sw_addr_t             address,
  input  logic                 read_en,
  input  logic                 write_en,
  input  logic [DATA_W-1:0]    write_data,
  output logic [DATA_W-1:0]    read_data,
  output logic                 invalid_address,
  output logic                 access_complete,
  input  logic [RAM_AW-1:0]    TestRAM_addr,
  input  logic                 TestRAM_ren,
  output logic [RAM_WIDTH-1:0] TestRAM_rdata,
  input  logic                 TestRAM_wen,
  input  logic [RAM_WIDTH-1:0] TestRAM_wdata
);

  state_t               state, state_next;
  logic                 sw_wen, sw_ren, wr_done;
  logic [RAM_WIDTH-1:0] sw_rdata;
  logic                 unused_wdata;

  assign unused_wdata = ^write_data[DATA_W-1:RAM_WIDTH];

  // Any non-idle state completes on the next edge, so strobes seen there are dropped.
  always_comb begin
    state_next = state;
    sw_wen     = 1'b0;
    sw_ren     = 1'b0;
    wr_done    = 1'b0;
    if (!res_n) begin
      case (state)
        ST_IDLE: begin
          if (write_en) begin
            if (addr_valid(address)) begin
              sw_wen  = 1'b1;
              wr_done = 1'b1;
            end else begin
              state_next = ST_INV_WR;
            end
          end else if (read_en) begin
            if (addr_valid(address)) begin
              sw_ren     = 1'b1;
              state_next = ST_READ;
            end else begin
              state_next = ST_INV_RD;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res_n) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (res_n) begin
      read_data       <= '0;
      access_complete <= 1'b0;
      invalid_address <= 1'b0;
    end else begin
      access_complete <= wr_done || (state != ST_IDLE);
      invalid_address <= (state == ST_INV_RD) || (state == ST_INV_WR);
      if (state == ST_READ)
        read_data <= {{(DATA_W - RAM_WIDTH){1'b0}}, sw_rdata};
      else if (state == ST_INV_RD)
        read_data <= '0;
    end
  end

  ram_rf_dpram #(
    .DEPTH(RAM_DEPTH),
    .WIDTH(RAM_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (res_n),
    .a_addr (ram_index(address)),
    .a_ren  (sw_ren),
    .a_wen  (sw_wen),
    .a_wdata(write_data[RAM_WIDTH-1:0]),
    .a_rdata(sw_rdata),
    .b_addr (TestRAM_addr),
    .b_ren  (TestRAM_ren),
    .b_wen  (TestRAM_wen),
    .b_wdata(TestRAM_wdata),
    .b_rdata(TestRAM_rdata)
  );

endmodule

// File: tb/tb_ram_rf.sv
// Directed plus randomized bench for ram_rf against an array model of TestRAM.
module tb_ram_rf;

  logic        clk = 1'b0;
  logic        res_n;
  logic [8:3]  address;
  logic        read_en, write_en;
  logic [63:0] write_data, read_data;
  logic        invalid_address, access_complete;
  logic [4:0]  TestRAM_addr;
  logic        TestRAM_ren, TestRAM_wen;
  logic [15:0] TestRAM_rdata, TestRAM_wdata;

  logic [15:0] model [32];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  ram_rf dut (
    .clk            (clk),
    .res_n          (res_n),
    .address        (address),
    .read_en        (read_en),
    .write_en       (write_en),
    .write_data     (write_data),
    .read_data      (read_data),
    .invalid_address(invalid_address),
    .access_complete(access_complete),
    .TestRAM_addr   (TestRAM_addr),
    .TestRAM_ren    (TestRAM_ren),
    .TestRAM_rdata  (TestRAM_rdata),
    .TestRAM_wen    (TestRAM_wen),
    .TestRAM_wdata  (TestRAM_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic sw_read(input int unsigned a, input logic [63:0] exp, input logic exp_inv);
    address = 6'(a);
    read_en = 1'b1;
    tick();
    read_en = 1'b0;
    check_bit("rd_inflight_cmp", access_complete, 1'b0);
    tick();
    check_bit("rd_cmp", access_complete, 1'b1);
    check_bit("rd_inv", invalid_address, exp_inv);
    check_word("rd_data", read_data, exp);
    tick();
    check_bit("rd_cmp_end", access_complete, 1'b0);
    check_bit("rd_inv_end", invalid_address, 1'b0);
  endtask

  task automatic hw_read(input int unsigned idx);
    TestRAM_addr = 5'(idx);
    TestRAM_ren  = 1'b1;
    tick();
    TestRAM_ren  = 1'b0;
    check_word("hw_rd", 64'(TestRAM_rdata), 64'(model[idx]));
  endtask

  initial begin
    int unsigned op, idx, idx2;
    logic [15:0] d, d2, old;
    logic        hw_w;

    res_n = 1'b1; address = '0; read_en = 1'b0; write_en = 1'b0; write_data = '0;
    TestRAM_addr = '0; TestRAM_ren = 1'b0; TestRAM_wen = 1'b0; TestRAM_wdata = '0;
    foreach (model[i]) model[i] = '0;

    // Reset with strobes active: nothing may complete.
    read_en = 1'b1; address = 6'd40; TestRAM_ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit("rst_cmp", access_complete, 1'b0);
      check_bit("rst_inv", invalid_address, 1'b0);
      check_word("rst_rdata", read_data, 64'h0);
      check_word("rst_hw_rdata", 64'(TestRAM_rdata), 64'h0);
    end
    read_en = 1'b0; TestRAM_ren = 1'b0; res_n = 1'b0;
    tick();

    // Back-to-back SW writes, data = word address.
    for (int i = 0; i < 32; i++) begin
      address    = 6'(32 + i);
      write_en   = 1'b1;
      write_data = {32'($urandom), 16'($urandom), 16'(32 + i)};
      model[i]   = 16'(32 + i);
      tick();
      check_bit("wr_cmp", access_complete, 1'b1);
      check_bit("wr_inv", invalid_address, 1'b0);
    end
    write_en = 1'b0;
    tick();
    check_bit("wr_cmp_end", access_complete, 1'b0);

    TestRAM_ren = 1'b1;
    for (int i = 0; i < 32; i++) begin
      TestRAM_addr = 5'(i);
      tick();
      check_word("hw_sweep", 64'(TestRAM_rdata), 64'(model[i]));
    end
    TestRAM_ren = 1'b0; TestRAM_addr = 5'd3;
    tick();
    check_word("hw_hold", 64'(TestRAM_rdata), 64'(model[31]));

    TestRAM_wen = 1'b1;
    for (int i = 0; i < 32; i++) begin
      TestRAM_addr  = 5'(i);
      TestRAM_wdata = 16'(i);
      model[i]      = 16'(i);
      tick();
    end
    TestRAM_wen = 1'b0;
    for (int i = 32; i < 64; i++) sw_read(i, 64'(model[i-32]), 1'b0);

    // Invalid write: delayed flagged completion, read_data held, RAM untouched.
    sw_read(39, 64'(model[7]), 1'b0);
    address = 6'd0; write_en = 1'b1; write_data = 64'hBEEF;
    tick();
    write_en = 1'b0;
    check_bit("invwr_early", access_complete, 1'b0);
    tick();
    check_bit("invwr_cmp", access_complete, 1'b1);
    check_bit("invwr_inv", invalid_address, 1'b1);
    check_word("invwr_rdata_hold", read_data, 64'(model[7]));
    tick();
    check_bit("invwr_inv_end", invalid_address, 1'b0);
    hw_read(0);
    sw_read(5, 64'h0, 1'b1);
    hw_read(5);

    // Same-cycle collision: software wins.
    address = 6'd40; write_en = 1'b1; write_data = 64'hAAAA;
    TestRAM_wen = 1'b1; TestRAM_addr = 5'd8; TestRAM_wdata = 16'h5555;
    tick();
    write_en = 1'b0; TestRAM_wen = 1'b0;
    model[8] = 16'hAAAA;
    check_bit("coll_cmp", access_complete, 1'b1);
    hw_read(8);

    // Read-first on the hardware port during a SW write.
    address = 6'd40; write_en = 1'b1; write_data = 64'h1111;
    TestRAM_ren = 1'b1; TestRAM_addr = 5'd8;
    tick();
    write_en = 1'b0; TestRAM_ren = 1'b0;
    check_word("rfirst_hw", 64'(TestRAM_rdata), 64'hAAAA);
    model[8] = 16'h1111;
    hw_read(8);

    // Read-first on the SW port during a HW write.
    old = model[9];
    address = 6'd41; read_en = 1'b1;
    TestRAM_wen = 1'b1; TestRAM_addr = 5'd9; TestRAM_wdata = 16'h7777;
    tick();
    read_en = 1'b0; TestRAM_wen = 1'b0;
    model[9] = 16'h7777;
    tick();
    check_bit("rfirst_sw_cmp", access_complete, 1'b1);
    check_word("rfirst_sw", read_data, 64'(old));
    tick();
    hw_read(9);

    // Both strobes: one write completion only.
    address = 6'd33; read_en = 1'b1; write_en = 1'b1; write_data = 64'h1234;
    tick();
    read_en = 1'b0; write_en = 1'b0;
    model[1] = 16'h1234;
    check_bit("both_cmp", access_complete, 1'b1);
    tick();
    check_bit("both_single1", access_complete, 1'b0);
    tick();
    check_bit("both_single2", access_complete, 1'b0);
    sw_read(33, 64'h1234, 1'b0);

    // Write arriving while a read is in flight is dropped.
    address = 6'd34; read_en = 1'b1;
    tick();
    read_en = 1'b0; address = 6'd35; write_en = 1'b1; write_data = 64'hDEAD;
    tick();
    write_en = 1'b0;
    check_bit("busy_cmp", access_complete, 1'b1);
    check_word("busy_rdata", read_data, 64'(model[2]));
    tick();
    check_bit("busy_drop", access_complete, 1'b0);
    sw_read(35, 64'(model[3]), 1'b0);

    // Reset during an in-flight read drops its completion.
    address = 6'd36; read_en = 1'b1;
    tick();
    read_en = 1'b0; res_n = 1'b1;
    tick();
    check_bit("rstmid_cmp", access_complete, 1'b0);
    check_word("rstmid_rdata", read_data, 64'h0);
    res_n = 1'b0;
    tick();
    check_bit("rstmid_after", access_complete, 1'b0);
    hw_read(4);

    for (int n = 0; n < 60; n++) begin
      op  = $urandom_range(0, 3);
      idx = $urandom_range(0, 31);
      d   = 16'($urandom);
      case (op)
        0: begin
          idx2 = $urandom_range(0, 31);
          d2   = 16'($urandom);
          hw_w = 1'($urandom_range(0, 1));
          address = 6'(32 + idx); write_en = 1'b1;
          write_data = {32'($urandom), 16'($urandom), d};
          TestRAM_wen = hw_w; TestRAM_addr = 5'(idx2); TestRAM_wdata = d2;
          tick();
          write_en = 1'b0; TestRAM_wen = 1'b0;
          if (hw_w) model[idx2] = d2;
          model[idx] = d;
          check_bit("rnd_wr_cmp", access_complete, 1'b1);
        end
        1: sw_read(32 + idx, 64'(model[idx]), 1'b0);
        2: hw_read(idx);
        default: sw_read(idx, 64'h0, 1'b1);
      endcase
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_rf.md
Name: ram_rf

Overview:
- Register-file block exposing one 32 x 16-bit RAM (TestRAM) to two masters:
  - a software register bus (word-addressed, 64-bit data, strobe/complete handshake);
  - a hardware port with direct RAM access.
- RAM occupies software word addresses 32..63; all other addresses are invalid.
- Sits between the host register interconnect and the hardware logic that owns TestRAM.

Parameters:
- RAM_DEPTH, 32, number of RAM entries (hardware address width = 5).
- RAM_WIDTH, 16, RAM data width in bits.
- RAM_BASE, 32, first software word address mapped to RAM entry 0.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- res_n  in  1  synchronous reset, active-high: res_n=1 holds the block in reset.
- address  in  6 ([8:3])  software word address (byte address bits 8..3).
- read_en  in  1  software read strobe.
- write_en  in  1  software write strobe.
- write_data  in  64  software write data.
- read_data  out  64  software read data.
- invalid_address  out  1  flags completion of an access to an unmapped address.
- access_complete  out  1  one-cycle completion pulse for each accepted software access.
- TestRAM_addr  in  5  hardware-port RAM index.
- TestRAM_ren  in  1  hardware read enable.
- TestRAM_rdata  out  16  hardware read data.
- TestRAM_wen  in  1  hardware write enable.
- TestRAM_wdata  in  16  hardware write data.

Behaviour:
- Reset (res_n=1 at a rising edge): read_data=0, access_complete=0, invalid_address=0, TestRAM_rdata=0, read pipeline cleared.
- RAM contents are not reset.
- Address decode:
  - address[8]=1 -> valid, RAM index = address[7:3];
  - address[8]=0 -> invalid.
- Software write (write_en=1 at edge N, block idle):
  - valid address: RAM[idx] <= write_data[15:0] at edge N; write_data[63:16] ignored.
  - access_complete=1 for exactly cycle N..N+1.
  - Back-to-back writes on consecutive cycles are accepted.
- Software read (read_en=1 at edge N, block idle):
  - RAM read at edge N; at edge N+1 read_data <= {48'b0, RAM[idx]} and access_complete pulses for one cycle.
  - read_data holds its value until the next completed read.
- Invalid address (read or write):
  - no RAM access; at the next edge access_complete=1 and invalid_address=1 for one cycle.
  - on a read, read_data <= 0.
  - invalid_address is 0 on every other cycle.
- read_en and write_en both high in the same cycle: write is performed, read is ignored.
- Busy rule: strobes arriving while a read is in flight (the cycle before its completion) are ignored.
- Hardware read: TestRAM_ren=1 at edge N -> TestRAM_rdata <= RAM[TestRAM_addr] at edge N; value held while ren=0.
- Hardware write: TestRAM_wen=1 at edge N -> RAM[TestRAM_addr] <= TestRAM_wdata.
- Both ports operate concurrently every cycle (true dual-port).
- Same-cycle writes from both ports to the same index: software value wins.
- Read-during-write on the same index (either port): read-first, returning the old data.
- Reset asserted mid-read: the pending completion is dropped and no access_complete is issued.

Decomposition:
- Package ram_rf_pkg: RAM_DEPTH, RAM_WIDTH, RAM_BASE, address/data width constants, decode helper function.
- One sub-module, ram_rf_dpram: true dual-port 32x16 synchronous RAM, read-first, port A priority on write collision.
- Top level holds decode, handshake/complete logic and output registers.

Test Plan:
- Reset: res_n=1 for 4 cycles -> all outputs 0, no access_complete.
- SW writes addresses 32..63 back-to-back with data=i; then HW ren sweeps TestRAM_addr 0..31 -> TestRAM_rdata = idx+32 one cycle after each address.
- HW writes TestRAM_wdata=idx to addresses 0..31; SW reads addresses 32..63 -> each access_complete pulse carries read_data = i-32, invalid_address=0.
- SW read of address 5 and SW write of address 0 -> access_complete plus invalid_address one cycle later; read_data=0; RAM unchanged (verify via HW read).
- Same cycle: SW write addr 40 data 0xAAAA and HW write idx 8 data 0x5555 -> RAM[8]=0xAAAA.
- read_en+write_en together at addr 33 with data 0x1234 -> single completion; subsequent read returns 0x1234.
